// File: rtl/pile_card_reader_pkg.sv
// Shared definitions for the pile card reader: card field layout, suit
// encodings, pile geometry, FSM state type and the slot extraction helper.
package pile_card_reader_pkg;

    localparam int CARD_SIZE        = 7;
    localparam int MAX_TABLEAU_SIZE = 19;
    localparam int PILE_DEPTH       = MAX_TABLEAU_SIZE;
    localparam int IDX_W            = $clog2(PILE_DEPTH + 1);
    localparam int PILE_W           = PILE_DEPTH * CARD_SIZE;
    localparam int RANK_W           = 4;

    // Field offsets inside one card
    localparam int RANK_LSB    = 3;
    localparam int SUIT_LSB    = 1;
    localparam int FACE_UP_BIT = 0;

    localparam logic [3:0] RANK_EMPTY = 4'd0;

    typedef enum logic [1:0] {
        SUIT_HEARTS   = 2'd0,
        SUIT_CLUBS    = 2'd1,
        SUIT_DIAMONDS = 2'd2,
        SUIT_SPADES   = 2'd3
    } suit_e;

    typedef struct packed {
        logic [3:0] rank;
        suit_e      suit;
        logic       face_up;
    } card_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Pull slot idx out of a packed pile vector
    function automatic card_t slot_card(input logic [PILE_W-1:0] pile,
                                        input logic [IDX_W-1:0]  idx);
        return card_t'(pile[int'(idx) * CARD_SIZE +: CARD_SIZE]);
    endfunction

endpackage

// File: rtl/pile_card_reader_height_enc.sv
// Lowest-empty-slot encoder: returns the index of the first slot whose rank
// is empty, or PILE_DEPTH when every slot holds a card. Anything above the
// first gap is treated as not part of the pile.
module pile_card_reader_height_enc
    import pile_card_reader_pkg::*;
(
    input  logic [PILE_DEPTH*RANK_W-1:0] ranks,
    output logic [IDX_W-1:0]             height
);

    logic [IDX_W-1:0] height_s;

    // Scan from the top down so the lowest empty slot wins
    always_comb begin
        height_s = IDX_W'(PILE_DEPTH);
        for (int i = PILE_DEPTH - 1; i >= 0; i--) begin
            if (ranks[i*RANK_W +: RANK_W] == RANK_EMPTY) begin
                height_s = IDX_W'(i);
            end else begin
                height_s = height_s;
            end
        end
    end

    assign height = height_s;

endmodule

// File: rtl/pile_card_reader.sv
// Pile card reader: snapshots a packed pile on start and streams its cards,
// one per valid/ready handshake, bottom-first or top-first.
// Optional build macro SOLITAIRE_HIDE_FACEDOWN_EN: face-down cards are
// presented as 7'h00 instead of their captured value.
module pile_card_reader
    import pile_card_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  top_first,
    input  logic [PILE_W-1:0]     pile_in,
    output logic                  busy,
    output logic                  card_valid,
    input  logic                  card_ready,
    output logic [CARD_SIZE-1:0]  card_data,
    output logic [IDX_W-1:0]      card_index,
    output logic                  card_last,
    output logic [IDX_W-1:0]      card_count,
    output logic                  done
);

    state_e                  state_r, state_s;
    logic [PILE_W-1:0]       snap_r;
    logic                    top_first_r;
    logic [IDX_W-1:0]        ptr_r, ptr_s;
    logic [IDX_W-1:0]        remaining_r, remaining_s;
    logic [IDX_W-1:0]        card_count_r;
    logic                    capture_s;
    logic [PILE_DEPTH*RANK_W-1:0] ranks_s;
    logic [IDX_W-1:0]        height_s;
    card_t                   raw_card_s;
    card_t                   out_card_s;

    logic                    busy_r, card_valid_r, card_last_r, done_r;
    logic [CARD_SIZE-1:0]    card_data_r;
    logic [IDX_W-1:0]        card_index_r;

    // Gather the rank field of every incoming slot for the height encoder
    always_comb begin
        ranks_s = '0;
        for (int i = 0; i < PILE_DEPTH; i++) begin
            ranks_s[i*RANK_W +: RANK_W] = pile_in[i*CARD_SIZE + RANK_LSB +: RANK_W];
        end
    end

    pile_card_reader_height_enc u_height_enc (
        .ranks  (ranks_s),
        .height (height_s)
    );

    // Next-state logic: capture, pointer setup, per-handshake advance
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        remaining_s = remaining_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    capture_s = 1'b1;
                    state_s   = ST_LOAD;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (card_count_r == {IDX_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s     = ST_SEND;
                    ptr_s       = top_first_r ? (card_count_r - 5'd1) : 5'd0;
                    remaining_s = card_count_r;
                end
            end
            ST_SEND: begin
                if (card_valid_r && card_ready) begin
                    if (remaining_r == 5'd1) begin
                        state_s = ST_DONE;
                    end else begin
                        ptr_s       = top_first_r ? (ptr_r - 5'd1) : (ptr_r + 5'd1);
                        remaining_s = remaining_r - 5'd1;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Card presented for the upcoming cycle, masked when hiding face-down cards
    always_comb begin
        raw_card_s = slot_card(snap_r, ptr_s);
`ifdef SOLITAIRE_HIDE_FACEDOWN_EN
        if (raw_card_s.face_up) begin
            out_card_s = raw_card_s;
        end else begin
            out_card_s = card_t'(7'h00);
        end
`else
        out_card_s = raw_card_s;
`endif
    end

    // State, pointer and snapshot registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 5'd0;
            remaining_r  <= 5'd0;
            snap_r       <= '0;
            top_first_r  <= 1'b0;
            card_count_r <= 5'd0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            remaining_r <= remaining_s;
            if (capture_s) begin
                snap_r       <= pile_in;
                top_first_r  <= top_first;
                card_count_r <= height_s;
            end else begin
                snap_r       <= snap_r;
                top_first_r  <= top_first_r;
                card_count_r <= card_count_r;
            end
        end
    end

    // Output registers, loaded from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= 1'b0;
            card_valid_r <= 1'b0;
            card_data_r  <= 7'h00;
            card_index_r <= 5'd0;
            card_last_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            busy_r       <= (state_s == ST_LOAD) || (state_s == ST_SEND);
            card_valid_r <= (state_s == ST_SEND);
            card_data_r  <= (state_s == ST_SEND) ? CARD_SIZE'(out_card_s) : 7'h00;
            card_index_r <= (state_s == ST_SEND) ? ptr_s : 5'd0;
            card_last_r  <= (state_s == ST_SEND) && (remaining_s == 5'd1);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign busy       = busy_r;
    assign card_valid = card_valid_r;
    assign card_data  = card_data_r;
    assign card_index = card_index_r;
    assign card_last  = card_last_r;
    assign card_count = card_count_r;
    assign done       = done_r;

endmodule
